// File: rtl/hashcore_nonce_ctl.sv
// Nonce generator for one hashing core: walks a programmable counter range under a
// fixed core-ID prefix and queues latency-corrected golden nonces for the comms block.
module hashcore_nonce_ctl #(
   parameter int PREFIX_BITS = 1,
   parameter int LATENCY     = 65,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                    hash_clk,
   input  logic                    reset,
   input  logic                    work_load,
   input  logic [PREFIX_BITS-1:0]  core_id,
   input  logic [31-PREFIX_BITS:0] nonce_start,
   input  logic [31-PREFIX_BITS:0] nonce_end,
   output logic [31:0]             nonce,
   input  logic                    gn_match,
   output logic                    gn_valid,
   output logic [31:0]             gn_data,
   input  logic                    gn_ready,
   output logic                    running,
   output logic                    exhausted,
   output logic                    overflow,
   output logic [1:0]              dbg_state
);

   localparam int CW = 32 - PREFIX_BITS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAT_CW = CW'(LATENCY);
   localparam logic [7:0]    LAT8   = 8'(LATENCY);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [7:0]    blank;
   logic [7:0]    drain;
   logic          active;
   logic          accept;
   logic [31:0]   golden;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;

   assign active    = (state == RUN) || (state == DRAIN);
   assign running   = active;
   assign exhausted = (state == DONE);
   assign dbg_state = state;

   // blank masks matches still in flight from the previous work unit
   assign accept = gn_match && active && (blank == 8'd0);
   assign golden = {core_id, cnt - LAT_CW};

   always_comb begin
      cnt_nxt = cnt;
      if (work_load) begin
         cnt_nxt = nonce_start;
      end else if (active) begin
         cnt_nxt = cnt + CW'(1);
      end
   end

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         nonce <= '0;
         blank <= '0;
         drain <= '0;
      end else begin
         cnt <= cnt_nxt;
         // nonce only follows the counter while hashing, so it reads 0 until the first load
         if (work_load || active) begin
            nonce <= {core_id, cnt_nxt};
         end
         if (active && (blank != 8'd0)) begin
            blank <= blank - 8'd1;
         end
         if (work_load) begin
            state <= RUN;
            blank <= LAT8;
         end else begin
            case (state)
               RUN: begin
                  if (cnt == nonce_end) begin
                     state <= DRAIN;
                     drain <= LAT8;
                  end
               end
               DRAIN: begin
                  if (drain == 8'd1) begin
                     state <= DONE;
                  end else begin
                     drain <= drain - 8'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Handshake: gn_data is offered whenever gn_valid is high and is held unchanged until
   // the consumer takes it; a transfer happens on each rising edge with gn_valid && gn_ready.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop      = !empty && gn_ready;
   assign push     = accept && (!full || pop);
   assign gn_valid = !empty;
   assign gn_data  = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= golden;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (work_load) begin
            overflow <= 1'b0;
         end else if (accept && !push) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hashcore_nonce_ctl.sv
// Directed bench for hashcore_nonce_ctl: one instance at LATENCY=4 for most sequences,
// a second at LATENCY=65 for the long back-correction case.
module tb_hashcore_nonce_ctl;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic        clk = 1'b0;
   logic        reset;
   logic        work_load;
   logic [0:0]  core_id;
   logic [30:0] nonce_start;
   logic [30:0] nonce_end;
   logic        gn_match;
   logic        rdy4;
   logic        rdy65;

   logic [31:0] nonce4, gn_data4, nonce65, gn_data65;
   logic        gn_valid4, running4, exhausted4, overflow4;
   logic        gn_valid65, running65, exhausted65, overflow65;
   logic [1:0]  state4, state65;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        match;
      logic [31:0] nonce;
      logic        run;
      logic        exh;
      logic        valid;
      logic [31:0] data;
   } vec_t;
   vec_t vecs[10];

   hashcore_nonce_ctl #(.PREFIX_BITS(1), .LATENCY(4), .FIFO_DEPTH(4)) u_l4 (
      .hash_clk(clk), .reset(reset), .work_load(work_load), .core_id(core_id),
      .nonce_start(nonce_start), .nonce_end(nonce_end), .nonce(nonce4),
      .gn_match(gn_match), .gn_valid(gn_valid4), .gn_data(gn_data4), .gn_ready(rdy4),
      .running(running4), .exhausted(exhausted4), .overflow(overflow4), .dbg_state(state4)
   );

   hashcore_nonce_ctl #(.PREFIX_BITS(1), .LATENCY(65), .FIFO_DEPTH(4)) u_l65 (
      .hash_clk(clk), .reset(reset), .work_load(work_load), .core_id(core_id),
      .nonce_start(nonce_start), .nonce_end(nonce_end), .nonce(nonce65),
      .gn_match(gn_match), .gn_valid(gn_valid65), .gn_data(gn_data65), .gn_ready(rdy65),
      .running(running65), .exhausted(exhausted65), .overflow(overflow65), .dbg_state(state65)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // driver tasks
   task automatic do_load(input logic [30:0] s, input logic [30:0] e);
      nonce_start = s;
      nonce_end   = e;
      work_load   = 1'b1;
      tick();
      work_load   = 1'b0;
   endtask

   task automatic pulse_match();
      gn_match = 1'b1;
      tick();
      gn_match = 1'b0;
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d entries outstanding, expected 0", exp_q.size());
      end
   endtask

   // scoreboard: every transfer from the LATENCY=4 instance must match the queue head
   always @(negedge clk) begin
      if (!reset && gn_valid4 && rdy4) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h, expected no entry", gn_data4);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (gn_data4 !== e) begin
               errors++;
               $display("FAIL sb_data: got %h, expected %h", gn_data4, e);
            end
         end
      end
   end

   initial begin
      vecs[0] = '{1'b0, 32'h80000010, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 32'h80000011, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{1'b0, 32'h80000012, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{1'b0, 32'h80000013, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 32'h80000014, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 32'h80000015, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{1'b1, 32'h80000016, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[7] = '{1'b1, 32'h80000017, 1'b0, 1'b1, 1'b1, 32'h80000012};
      vecs[8] = '{1'b0, 32'h80000017, 1'b0, 1'b1, 1'b1, 32'h80000012};
      vecs[9] = '{1'b0, 32'h80000017, 1'b0, 1'b1, 1'b1, 32'h80000012};

      work_load   = 1'b0;
      core_id     = 1'b1;
      nonce_start = '0;
      nonce_end   = '0;
      gn_match    = 1'b0;
      rdy4        = 1'b0;
      rdy65       = 1'b0;

      // reset state
      do_reset();
      check32("rst_nonce", nonce4, 32'h0);
      check32("rst_valid", {31'd0, gn_valid4}, 32'd0);
      check32("rst_data", gn_data4, 32'h0);
      check32("rst_running", {31'd0, running4}, 32'd0);
      check32("rst_exhausted", {31'd0, exhausted4}, 32'd0);
      check32("rst_overflow", {31'd0, overflow4}, 32'd0);
      check32("rst_state", {30'd0, state4}, {30'd0, ST_IDLE});
      check32("rst_nonce65", nonce65, 32'h0);

      // long latency back-correction
      do_load(31'h7fbd9205, 31'h7fbd9211);
      check32("l65_first_nonce", nonce65, 32'hffbd9205);
      repeat (67) tick();
      check32("l65_valid_before", {31'd0, gn_valid65}, 32'd0);
      pulse_match();
      check32("l65_valid", {31'd0, gn_valid65}, 32'd1);
      check32("l65_data", gn_data65, 32'hffbd9207);
      check32("l65_overflow", {31'd0, overflow65}, 32'd0);

      // short range, cycle by cycle
      do_reset();
      do_load(31'h10, 31'h12);
      for (int i = 0; i < 10; i++) begin
         check32($sformatf("vec%0d_nonce", i), nonce4, vecs[i].nonce);
         check32($sformatf("vec%0d_running", i), {31'd0, running4}, {31'd0, vecs[i].run});
         check32($sformatf("vec%0d_exhausted", i), {31'd0, exhausted4}, {31'd0, vecs[i].exh});
         check32($sformatf("vec%0d_valid", i), {31'd0, gn_valid4}, {31'd0, vecs[i].valid});
         if (vecs[i].valid) check32($sformatf("vec%0d_data", i), gn_data4, vecs[i].data);
         gn_match = vecs[i].match;
         tick();
         gn_match = 1'b0;
      end
      exp_q.push_back(32'h80000012);
      rdy4 = 1'b1;
      wait_drain();
      check32("short_empty", {31'd0, gn_valid4}, 32'd0);
      rdy4 = 1'b0;

      // counter wrap keeps the prefix
      do_reset();
      rdy4 = 1'b1;
      do_load(31'h7ffffffe, 31'h00000001);
      check32("wrap_n0", nonce4, 32'hfffffffe);
      tick();
      check32("wrap_n1", nonce4, 32'hffffffff);
      tick();
      check32("wrap_n2", nonce4, 32'h80000000);
      repeat (3) tick();
      exp_q.push_back(32'hffffffff);
      pulse_match();
      exp_q.push_back(32'h80000000);
      pulse_match();
      wait_drain();
      check32("wrap_empty", {31'd0, gn_valid4}, 32'd0);
      rdy4 = 1'b0;

      // overflow, pop with simultaneous push, then reload blanking
      do_reset();
      do_load(31'h100, 31'hfff);
      repeat (4) tick();
      for (int j = 0; j < 5; j++) pulse_match();
      exp_q.push_back(32'h80000100);
      exp_q.push_back(32'h80000101);
      exp_q.push_back(32'h80000102);
      exp_q.push_back(32'h80000103);
      check32("ovf_set", {31'd0, overflow4}, 32'd1);
      check32("ovf_head", gn_data4, 32'h80000100);
      exp_q.push_back(32'h80000105);
      rdy4 = 1'b1;
      pulse_match();
      rdy4 = 1'b0;
      check32("ovf_sticky", {31'd0, overflow4}, 32'd1);
      check32("ovf_head2", gn_data4, 32'h80000101);
      do_load(31'h300, 31'hfff);
      check32("reload_ovf_clr", {31'd0, overflow4}, 32'd0);
      pulse_match();
      tick();
      pulse_match();
      check32("blank_no_ovf", {31'd0, overflow4}, 32'd0);
      check32("blank_valid", {31'd0, gn_valid4}, 32'd1);
      rdy4 = 1'b1;
      repeat (4) tick();
      check32("blank_empty", {31'd0, gn_valid4}, 32'd0);
      exp_q.push_back(32'h80000303);
      pulse_match();
      wait_drain();
      check32("reload_empty", {31'd0, gn_valid4}, 32'd0);
      rdy4 = 1'b0;

      // reset during DRAIN with a queued entry, work_load overridden
      do_reset();
      do_load(31'h20, 31'h25);
      repeat (4) tick();
      pulse_match();
      tick();
      tick();
      check32("drain_state", {30'd0, state4}, {30'd0, ST_DRAIN});
      check32("drain_running", {31'd0, running4}, 32'd1);
      check32("drain_data", gn_data4, 32'h80000020);
      reset     = 1'b1;
      work_load = 1'b1;
      tick();
      reset     = 1'b0;
      work_load = 1'b0;
      check32("rd_state", {30'd0, state4}, {30'd0, ST_IDLE});
      check32("rd_valid", {31'd0, gn_valid4}, 32'd0);
      check32("rd_exhausted", {31'd0, exhausted4}, 32'd0);
      check32("rd_running", {31'd0, running4}, 32'd0);
      check32("rd_nonce", nonce4, 32'h0);
      check32("rd_data", gn_data4, 32'h0);
      repeat (3) tick();
      check32("idle_hold_state", {30'd0, state4}, {30'd0, ST_IDLE});
      check32("idle_hold_nonce", nonce4, 32'h0);

      check32("sb_leftover", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
